countdown_ctrl: RTL and testbench

- Control FSM that sequences the 5-bit 30-second down counter.
- Turns two pushbuttons (start/pause, clear) into counter enable and load pulses.
- Generates the once-per-second decrement tick.
- Detects expiry and drives the status LED.
- Sits between the board buttons and the counter datapath.

---
 rtl/countdown_pkg.sv | 10 +
 rtl/btn_onepulse.sv | 15 +
 rtl/countdown_ctrl.sv | 73 +++++++
 tb/tb_countdown_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encodings and default sizing for the countdown controller
package countdown_pkg;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;
    localparam int CNT_W_DEF     = 5;
    localparam int START_VAL_DEF = 30;
    localparam int TICK_DIV_DEF  = 100000000;
endpackage

// File: rtl/btn_onepulse.sv
// btn_onepulse: synchronises an asynchronous button level and emits one pulse per press
module btn_onepulse (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    logic s1, s2, prev;
    // two-flop synchroniser followed by a history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {s1, s2, prev} <= '0;
        else      {s1, s2, prev} <= {btn, s1, s2};
    end
    assign pulse = s2 & ~prev;
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: button-driven control FSM for the down counter; define DONE_BLINK_EN to blink done_led in DONE
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int START_VAL = START_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [CNT_W-1:0] load_value,
    output logic [1:0]       state,
    output logic             running,
    output logic             done_led
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    logic          start_p, clear_p, tick, zero, led_nxt;
    logic [1:0]    state_nxt;
    logic [PW-1:0] presc, presc_inc, presc_nxt, done_cnt;

    btn_onepulse u_start (.clk(clk), .rst(rst), .btn(btn_start), .pulse(start_p));
    btn_onepulse u_clear (.clk(clk), .rst(rst), .btn(btn_clear), .pulse(clear_p));

    assign load_value = CNT_W'(START_VAL);
    assign zero       = cnt_value == '0;
    assign tick       = (state == S_RUN) && (presc == LAST);
    assign presc_inc  = (presc == LAST) ? '0 : presc + PW'(1);

`ifdef DONE_BLINK_EN
    assign done_cnt = presc_inc;
    assign led_nxt  = (state != S_DONE) | (done_led ^ (presc == LAST));
`else
    assign done_cnt = '0;
    assign led_nxt  = 1'b1;
`endif

    // clear beats every other event; expiry beats a pause request; a pause freezes the fraction
    always_comb begin
        state_nxt = clear_p                         ? S_IDLE  :
                    (state == S_IDLE  && start_p)   ? S_RUN   :
                    (state == S_RUN   && zero)      ? S_DONE  :
                    (state == S_RUN   && start_p)   ? S_PAUSE :
                    (state == S_PAUSE && start_p)   ? S_RUN   : state;
        presc_nxt = (state == S_RUN)   ? (start_p ? presc : presc_inc) :
                    (state == S_DONE)  ? done_cnt :
                    (state == S_PAUSE) ? presc : '0;
    end

    // state, prescaler and registered outputs; reset cancels any pulse in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            running  <= 1'b0;
            done_led <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            cnt_en   <= tick & ~zero & ~start_p & ~clear_p;
            cnt_load <= clear_p;
            running  <= state_nxt == S_RUN;
            done_led <= (state_nxt == S_DONE) & led_nxt;
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed table, corner sequences and random buttons against a reference model
module tb_countdown_ctrl;
    localparam int TD = 4, START = 30;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;
`ifdef DONE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
    logic [4:0] cnt, load_value;
    logic [1:0] state;
    logic cnt_en, cnt_load, running, done_led;
    int n_vec = 0, n_err = 0;
    int m_state = IDLE, m_frac = 0, m_cnt = START;
    bit m_en = 1'b0, m_load = 1'b0, m_led = 1'b0;
    bit [2:0] hs = '0, hc = '0;
    typedef struct {bit s; bit c; int n; int st; int cv;} vec_t;
    vec_t tbl[$];

    countdown_ctrl #(.TICK_DIV(TD), .CNT_W(5), .START_VAL(START)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .cnt_value(cnt), .cnt_en(cnt_en), .cnt_load(cnt_load), .load_value(load_value),
        .state(state), .running(running), .done_led(done_led)
    );

    always #5 clk = ~clk;

    // counter datapath driven by the controller
    always @(posedge clk or negedge rst)
        if (!rst) cnt <= 5'(START);
        else if (cnt_load) cnt <= load_value;
        else if (cnt_en && cnt != 0) cnt <= cnt - 5'd1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: a press reaches the controller two edges after its level is first sampled;
    // each second of RUN is TD cycles, expiry at zero, clear restarts from START
    always @(posedge clk or negedge rst) begin : model
        bit sp, cp, wrap;
        int ns, nc;
        if (!rst) begin
            m_state = IDLE; m_frac = 0; m_cnt = START;
            m_en = 0; m_load = 0; m_led = 0; hs = '0; hc = '0;
        end else begin
            sp = hs[1] & ~hs[2];
            cp = hc[1] & ~hc[2];
            hs = {hs[1:0], btn_start};
            hc = {hc[1:0], btn_clear};
            wrap = m_frac == TD - 1;
            nc = m_load ? START : (m_en && m_cnt > 0) ? m_cnt - 1 : m_cnt;
            ns = m_state;
            if (cp) ns = IDLE;
            else if (m_state == IDLE && sp) ns = RUN;
            else if (m_state == RUN && m_cnt == 0) ns = DONE;
            else if (m_state == RUN && sp) ns = PAUSE;
            else if (m_state == PAUSE && sp) ns = RUN;
            m_led  = ns == DONE && (m_state != DONE || !BLINK || (m_led ^ wrap));
            m_en   = m_state == RUN && wrap && !sp && !cp && m_cnt != 0;
            m_load = cp;
            if (m_state == RUN) m_frac = sp ? m_frac : (m_frac + 1) % TD;
            else if (m_state == DONE && BLINK) m_frac = (m_frac + 1) % TD;
            else if (m_state != PAUSE) m_frac = 0;
            m_state = ns;
            m_cnt = nc;
        end
    end

    // every cycle: all outputs and the counter against the model
    always @(negedge clk) begin
        chk("state", int'(state), m_state);
        chk("cnt_en", int'(cnt_en), int'(m_en));
        chk("cnt_load", int'(cnt_load), int'(m_load));
        chk("running", int'(running), int'(m_state == RUN));
        chk("done_led", int'(done_led), int'(m_led));
        chk("counter", int'(cnt), m_cnt);
        chk("load_value", int'(load_value), START);
    end

    initial begin
        int tog, prev;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn_start = i[0];
            btn_clear = i[1];
        end
        chk("rst_state", int'(state), IDLE);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_cnt_load", int'(cnt_load), 0);
        chk("rst_done_led", int'(done_led), 0);
        @(negedge clk); btn_start = 0; btn_clear = 0;
        @(negedge clk); rst = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", int'(state), IDLE);

        tbl.push_back('{1'b1, 1'b0,   3, RUN,   30});
        tbl.push_back('{1'b1, 1'b0,  13, RUN,   27});
        tbl.push_back('{1'b0, 1'b0,   3, RUN,   27});
        tbl.push_back('{1'b1, 1'b0,   3, PAUSE, 26});
        tbl.push_back('{1'b0, 1'b0,  20, PAUSE, 26});
        tbl.push_back('{1'b1, 1'b0,   3, RUN,   26});
        tbl.push_back('{1'b0, 1'b0,   3, RUN,   25});
        tbl.push_back('{1'b0, 1'b0, 101, DONE,   0});
        tbl.push_back('{1'b1, 1'b0,   5, DONE,   0});
        tbl.push_back('{1'b0, 1'b1,   4, IDLE,  30});
        tbl.push_back('{1'b0, 1'b0,   3, IDLE,  30});
        tbl.push_back('{1'b1, 1'b0,   3, RUN,   30});
        tbl.push_back('{1'b0, 1'b0,   3, RUN,   30});
        tbl.push_back('{1'b1, 1'b1,   4, IDLE,  30});
        tbl.push_back('{1'b0, 1'b0,   3, IDLE,  30});
        foreach (tbl[k]) begin
            btn_start = tbl[k].s;
            btn_clear = tbl[k].c;
            repeat (tbl[k].n) @(negedge clk);
            chk($sformatf("tbl%0d_state", k), int'(state), tbl[k].st);
            chk($sformatf("tbl%0d_count", k), int'(cnt), tbl[k].cv);
        end

        btn_start = 1; repeat (3) @(negedge clk);
        btn_start = 0; repeat (3) @(negedge clk);
        #2 rst = 0;
        #1;
        chk("midrun_rst_state", int'(state), IDLE);
        chk("midrun_rst_cnt_en", int'(cnt_en), 0);
        chk("midrun_rst_running", int'(running), 0);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk("midrun_rst_idle", int'(state), IDLE);

`ifdef DONE_BLINK_EN
        btn_start = 1; repeat (3) @(negedge clk);
        btn_start = 0; repeat (130) @(negedge clk);
        chk("blink_in_done", int'(state), DONE);
        tog = 0;
        prev = int'(done_led);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (int'(done_led) != prev) tog++;
            prev = int'(done_led);
        end
        chk("blink_toggles", tog, 4);
        btn_clear = 1; repeat (4) @(negedge clk);
        btn_clear = 0; repeat (3) @(negedge clk);
`endif

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(0, 31) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 149) == 0) btn_clear = ~btn_clear;
            rst = ($urandom_range(0, 999) != 0);
        end
        #2 rst = 1;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
